// File: rtl/xadc_drp_stream_adapter.sv
// Reads the two auxiliary XADC results over DRP once per end-of-sequence pulse and
// presents them as two independent 16-bit AXI-Stream sources (voltage, current-monitor).
module xadc_drp_stream_adapter #(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    ADDR_WIDTH   = 7,
    parameter logic [ADDR_WIDTH-1:0] VOLTAGE_ADDR = 7'h1C,
    parameter logic [ADDR_WIDTH-1:0] CURRENT_ADDR = 7'h14
) (
    input  logic                  xadc_dclk,
    input  logic                  xadc_reset,
    output logic [ADDR_WIDTH-1:0] xadc_daddr,
    output logic                  xadc_den,
    input  logic                  xadc_drdy,
    input  logic [DATA_WIDTH-1:0] xadc_do,
    input  logic                  xadc_eos,
    output logic [DATA_WIDTH-1:0] voltage_tdata,
    output logic                  voltage_tvalid,
    input  logic                  voltage_tready,
    output logic [DATA_WIDTH-1:0] current_tdata,
    output logic                  current_tvalid,
    input  logic                  current_tready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_V,
        S_WAIT_V,
        S_REQ_C,
        S_WAIT_C,
        S_PRESENT
    } state_t;

    state_t                r_state;
    logic                  r_pending;
    logic                  r_den;
    logic [ADDR_WIDTH-1:0] r_daddr;
    logic [DATA_WIDTH-1:0] r_v_data;
    logic [DATA_WIDTH-1:0] r_c_data;
    logic                  r_v_valid;
    logic                  r_c_valid;

    // A channel is finished once its beat is gone or is being accepted this cycle.
    logic w_v_done;
    logic w_c_done;
    assign w_v_done = !r_v_valid || voltage_tready;
    assign w_c_done = !r_c_valid || current_tready;

    always_ff @(posedge xadc_dclk) begin
        if (xadc_reset) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b0;
            r_den     <= 1'b0;
            r_daddr   <= '0;
            r_v_data  <= '0;
            r_c_data  <= '0;
            r_v_valid <= 1'b0;
            r_c_valid <= 1'b0;
        end else begin
            r_den <= 1'b0;
            // Any number of EOS pulses while busy collapse into one queued sweep.
            if (xadc_eos && r_state != S_IDLE)
                r_pending <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (xadc_eos || r_pending) begin
                        r_state   <= S_REQ_V;
                        r_pending <= 1'b0;
                        r_den     <= 1'b1;
                        r_daddr   <= VOLTAGE_ADDR;
                    end
                end
                S_REQ_V: r_state <= S_WAIT_V;
                S_WAIT_V: begin
                    if (xadc_drdy) begin
                        r_v_data <= xadc_do;
                        r_state  <= S_REQ_C;
                        r_den    <= 1'b1;
                        r_daddr  <= CURRENT_ADDR;
                    end
                end
                S_REQ_C: r_state <= S_WAIT_C;
                S_WAIT_C: begin
                    if (xadc_drdy) begin
                        r_c_data  <= xadc_do;
                        r_v_valid <= 1'b1;
                        r_c_valid <= 1'b1;
                        r_state   <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (r_v_valid && voltage_tready)
                        r_v_valid <= 1'b0;
                    if (r_c_valid && current_tready)
                        r_c_valid <= 1'b0;
                    if (w_v_done && w_c_done)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign xadc_den       = r_den;
    assign xadc_daddr     = r_daddr;
    assign voltage_tdata  = r_v_data;
    assign voltage_tvalid = r_v_valid;
    assign current_tdata  = r_c_data;
    assign current_tvalid = r_c_valid;

endmodule

// File: tb/tb_xadc_drp_stream_adapter.sv
// Randomized bench: DRP bus-functional model plus an AXIS scoreboard fed by the values the model returned.
module tb_xadc_drp_stream_adapter;

    localparam logic [6:0] VA = 7'h1C;
    localparam logic [6:0] CA = 7'h14;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        eos  = 1'b0;
    logic        drdy = 1'b0;
    logic [15:0] dout = '0;
    logic        vtr  = 1'b0;
    logic        ctr  = 1'b0;
    logic        den, vtv, ctv;
    logic [6:0]  daddr;
    logic [15:0] vtd, ctd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xadc_drp_stream_adapter dut (
        .xadc_dclk      (clk),
        .xadc_reset     (rst),
        .xadc_daddr     (daddr),
        .xadc_den       (den),
        .xadc_drdy      (drdy),
        .xadc_do        (dout),
        .xadc_eos       (eos),
        .voltage_tdata  (vtd),
        .voltage_tvalid (vtv),
        .voltage_tready (vtr),
        .current_tdata  (ctd),
        .current_tvalid (ctv),
        .current_tready (ctr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model/BFM state shared with the main sequence
    int          den_cnt = 0, v_beats = 0, c_beats = 0, bfm_cnt = 0;
    int          min_dly = 1, max_dly = 1, rdy_pct = 100, v_stall = 0;
    bit          fix_data = 1'b1, spur = 1'b0, stale = 1'b0, cur_drdy = 1'b0, pden = 1'b0;
    logic [6:0]  exp_addr = VA, pend_addr = '0;
    logic [15:0] pend_data = '0, pvd = '0, pcd = '0;
    logic        pvv = 1'b0, pvr = 1'b0, pcv = 1'b0, pcr = 1'b0;
    logic [15:0] exp_v[$], exp_c[$];

    // DRP responder and AXIS monitor, acting just after each rising edge.
    initial begin : bfm
        forever begin
            @(posedge clk);
            #1;
            drdy = 1'b0;
            if (v_stall > 0 && vtv) begin
                vtr = 1'b0;
                v_stall--;
            end else begin
                vtr = ($urandom_range(99, 0) < rdy_pct);
            end
            ctr = ($urandom_range(99, 0) < rdy_pct);
            if (rst) begin
                exp_v.delete();
                exp_c.delete();
                exp_addr = VA;
                if (bfm_cnt > 0) stale = 1'b1;
                cur_drdy = 1'b0;
                pvv = 1'b0; pcv = 1'b0; pden = 1'b0;
            end else begin
                if (cur_drdy) begin
                    check("v_tvalid_lat", vtv, 1);
                    check("c_tvalid_lat", ctv, 1);
                end
                cur_drdy = 1'b0;
                if (pvv && !pvr) begin
                    check("v_hold_valid", vtv, 1);
                    check("v_hold_data", vtd, pvd);
                end
                if (pcv && !pcr) begin
                    check("c_hold_valid", ctv, 1);
                    check("c_hold_data", ctd, pcd);
                end
                if (vtv && vtr) begin
                    check("v_beat_q", exp_v.size(), 1);
                    if (exp_v.size() > 0) check("v_data", vtd, exp_v.pop_front());
                    v_beats++;
                end
                if (ctv && ctr) begin
                    check("c_beat_q", exp_c.size(), 1);
                    if (exp_c.size() > 0) check("c_data", ctd, exp_c.pop_front());
                    c_beats++;
                end
                pvv = vtv; pvr = vtr; pvd = vtd;
                pcv = ctv; pcr = ctr; pcd = ctd;

                if (bfm_cnt > 0) begin
                    if (!stale) check("daddr_hold", daddr, pend_addr);
                    bfm_cnt--;
                    if (bfm_cnt == 0) begin
                        drdy = 1'b1;
                        dout = pend_data;
                        if (!stale) begin
                            if (pend_addr == VA) exp_v.push_back(pend_data);
                            else begin
                                exp_c.push_back(pend_data);
                                cur_drdy = 1'b1;
                            end
                        end
                        stale = 1'b0;
                    end
                end else if (spur) begin
                    drdy = 1'b1;
                    dout = 16'($urandom);
                    spur = 1'b0;
                end

                if (den) begin
                    check("den_double", pden, 0);
                    check("den_busy", bfm_cnt, 0);
                    check("daddr", daddr, exp_addr);
                    if (exp_addr == VA) check("den_while_present", vtv | ctv, 0);
                    den_cnt++;
                    pend_addr = daddr;
                    pend_data = fix_data ? ((daddr == VA) ? 16'h00FF : 16'h007F) : 16'($urandom);
                    bfm_cnt   = $urandom_range(max_dly, min_dly);
                    exp_addr  = (exp_addr == VA) ? CA : VA;
                end
                pden = den;
            end
        end
    end

    task automatic wait_idle();
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 2000) begin
            @(negedge clk);
            n++;
            if (bfm_cnt == 0 && !vtv && !ctv && !den && exp_v.size() == 0 && exp_c.size() == 0)
                quiet++;
            else
                quiet = 0;
        end
        check("quiesce", quiet >= 4, 1);
    endtask

    // One EOS from idle, optionally followed by extra EOS pulses while busy.
    task automatic sweep(input int extra);
        int d0 = den_cnt, vb = v_beats, cb = c_beats;
        @(negedge clk);
        eos = 1'b1;
        @(negedge clk);
        eos = 1'b0;
        check("den_latency", den, 1);
        for (int i = 0; i < extra; i++) begin
            eos = 1'b1;
            @(negedge clk);
            eos = 1'b0;
        end
        wait_idle();
        check("den_count", den_cnt - d0, (extra > 0) ? 4 : 2);
        check("v_beats", v_beats - vb, (extra > 0) ? 2 : 1);
        check("c_beats", c_beats - cb, (extra > 0) ? 2 : 1);
    endtask

    initial begin : main
        int d0, vb, cb, n;
        repeat (3) @(negedge clk);
        check("rst_den", den, 0);
        check("rst_daddr", daddr, 0);
        check("rst_vtvalid", vtv, 0);
        check("rst_ctvalid", ctv, 0);
        check("rst_vtdata", vtd, 0);
        check("rst_ctdata", ctd, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic sweep, always ready
        sweep(0);

        // Voltage backpressure, then a merged EOS queued behind the stalled beat
        v_stall = 5;
        sweep(0);
        v_stall = 5;
        min_dly = 4; max_dly = 4;
        sweep(3);

        // Reset while waiting for the current-monitor read
        min_dly = 10; max_dly = 10;
        d0 = den_cnt; vb = v_beats; cb = c_beats;
        @(negedge clk);
        eos = 1'b1;
        @(negedge clk);
        eos = 1'b0;
        n = 0;
        while (den_cnt < d0 + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait_c", den_cnt - d0, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_den", den, 0);
        check("mid_rst_daddr", daddr, 0);
        check("mid_rst_vtvalid", vtv, 0);
        check("mid_rst_ctvalid", ctv, 0);
        check("mid_rst_vtdata", vtd, 0);
        wait_idle();
        check("mid_rst_v_beats", v_beats - vb, 0);
        check("mid_rst_c_beats", c_beats - cb, 0);
        check("mid_rst_dens", den_cnt - d0, 2);
        min_dly = 1; max_dly = 2;
        sweep(0);

        // Slow DRP with a spurious drdy while idle
        min_dly = 10; max_dly = 10;
        d0 = den_cnt;
        spur = 1'b1;
        repeat (4) @(negedge clk);
        check("spur_vtvalid", vtv, 0);
        check("spur_ctvalid", ctv, 0);
        check("spur_den", den_cnt - d0, 0);
        sweep(0);

        // Randomized sweeps
        fix_data = 1'b0;
        for (int it = 0; it < 20; it++) begin
            min_dly = 1;
            max_dly = $urandom_range(6, 1);
            rdy_pct = $urandom_range(100, 30);
            v_stall = $urandom_range(3, 0);
            sweep($urandom_range(3, 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xadc_drp_stream_adapter.md
Name: xadc_drp_stream_adapter

Overview:
- Reads the two auxiliary XADC conversion results over the DRP port once per XADC end-of-sequence (EOS) pulse.
- Presents the results as two independent 16-bit AXI-Stream sources: voltage and current-monitor.
- Sits between the XADC primitive, or its bus-functional model, and the downstream packetizer/COBS framing logic.

Parameters:
DATA_WIDTH, 16, DRP data width and AXIS tdata width.
ADDR_WIDTH, 7, DRP address width.
VOLTAGE_ADDR, 7'h1C, DRP status address read for the voltage channel (VAUX12).
CURRENT_ADDR, 7'h14, DRP status address read for the current-monitor channel (VAUX4).

Ports:
xadc_dclk  in  1  single clock for all logic (XADC DCLK)
xadc_reset  in  1  synchronous, active-high reset
xadc_daddr  out  ADDR_WIDTH  DRP address
xadc_den  out  1  DRP enable, one-cycle pulse per read
xadc_drdy  in  1  DRP read data valid
xadc_do  in  DATA_WIDTH  DRP read data
xadc_eos  in  1  XADC end-of-sequence pulse
voltage_tdata  out  DATA_WIDTH  voltage sample
voltage_tvalid  out  1  voltage sample valid
voltage_tready  in  1  downstream ready, voltage
current_tdata  out  DATA_WIDTH  current-monitor sample
current_tvalid  out  1  current sample valid
current_tready  in  1  downstream ready, current

Behaviour:
- Interface: one clock, xadc_dclk. Reset xadc_reset is synchronous and active-high.
- Reset values:
  - xadc_den=0, xadc_daddr=0.
  - Both tvalid=0, both tdata=0.
  - FSM in IDLE; pending flag cleared.
- FSM states: IDLE, REQ_V, WAIT_V, REQ_C, WAIT_C, PRESENT.
- IDLE:
  - On xadc_eos=1, or pending=1, go to REQ_V and clear pending.
- REQ_V:
  - For exactly one cycle, drive xadc_den=1 and xadc_daddr=VOLTAGE_ADDR.
  - Next state is WAIT_V.
- WAIT_V:
  - xadc_den=0; xadc_daddr holds VOLTAGE_ADDR.
  - On xadc_drdy=1, register xadc_do into the voltage data register unchanged (full 16 bits, no shift or masking), then go to REQ_C.
- REQ_C and WAIT_C: same as REQ_V and WAIT_V, using CURRENT_ADDR and the current data register.
- PRESENT:
  - Assert voltage_tvalid and current_tvalid together, on the cycle after the current capture.
  - Each channel completes independently: on tvalid&&tready, that channel's tvalid drops on the next edge.
  - While tvalid=1 and tready=0, tdata and tvalid hold stable (AXIS rule). There is no combinational path from tready to tvalid.
  - When both channels have completed, including the case where both complete in the same cycle, return to IDLE.
- Latency: first xadc_den occurs 1 cycle after xadc_eos is sampled high. tvalid occurs 1 cycle after the second xadc_drdy.
- EOS while busy (any state other than IDLE):
  - Set the pending flag; one sweep is queued, extra EOS pulses are merged.
  - A queued sweep starts on the cycle after returning to IDLE.
- xadc_drdy outside WAIT_V/WAIT_C: ignored.
- Stalls: no DRP timeout; WAIT states wait indefinitely for drdy.
- Reset mid-operation:
  - Abort the sweep, drop captured data and deassert tvalid.
  - A drdy arriving after reset is ignored.
- Ordering: voltage is always read before current. Both samples of a sweep come from the same EOS.

Test Plan:
- Basic sweep: BFM returns 0x00FF @0x1C and 0x007F @0x14, tready tied 1, one EOS -> two den pulses, addresses 0x1C then 0x14; voltage_tdata=0x00FF and current_tdata=0x007F, tvalid high 1 cycle each.
- Backpressure: voltage_tready=0 for 5 cycles, current_tready=1 -> current accepted immediately; voltage_tvalid/tdata=0x00FF held stable 5 cycles; next sweep starts only after the voltage beat is accepted.
- EOS during sweep: second and third EOS while in WAIT_V -> exactly one extra sweep (4 den pulses total); second sample pair delivered identically.
- Reset mid-sweep: assert xadc_reset in WAIT_C -> den=0, tvalid=0, no AXIS beat; next EOS gives a clean full sweep with 0x00FF/0x007F.
- Slow DRP: drdy delayed 10 cycles, plus a spurious drdy in IDLE -> spurious drdy ignored; correct data captured; den never asserted twice per read.
- End-to-end with packetizer: the packetizer outputs COBS bytes 0x01 0x02 0xFF 0x02 0x7F 0x00.
